// File: rtl/pe_collect_pkg.sv
// pe_collect_pkg: shared sizing defaults and FSM state type for the PE result collector
package pe_collect_pkg;
    localparam int NUM_PE_DEF = 16;
    localparam int DATA_W_DEF = 256;
    localparam int IDX_W = $clog2(NUM_PE_DEF);
    typedef enum logic {COLLECT, DRAIN} state_t;
endpackage

// File: rtl/pe_result_slot_buf.sv
// pe_result_slot_buf: per-PE result slots with parallel write enables and an indexed read mux
module pe_result_slot_buf #(
    parameter int NUM_PE = 16,
    parameter int DATA_W = 256
) (
    input  logic                       clk,
    input  logic [NUM_PE-1:0]          we,
    input  logic [NUM_PE*DATA_W-1:0]   wdata,
    input  logic [$clog2(NUM_PE)-1:0]  rd_idx,
    output logic [DATA_W-1:0]          rd_data
);
    logic [DATA_W-1:0] mem [NUM_PE];
    // Contents are only meaningful once captured, so the slots carry no reset
    always_ff @(posedge clk)
        for (int i = 0; i < NUM_PE; i++)
            if (we[i]) mem[i] <= wdata[i*DATA_W +: DATA_W];
    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/pe_result_collector.sv
// pe_result_collector: captures out-of-order PE result groups and drains each tile as ordered beats
// Optional perf counters built when PE_COLLECT_PERF_EN is defined.
module pe_result_collector
    import pe_collect_pkg::*;
#(
    parameter int NUM_PE = pe_collect_pkg::NUM_PE_DEF,
    parameter int DATA_W = pe_collect_pkg::DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PE-1:0]          pe_out_valid_vec,
    input  logic [NUM_PE*DATA_W-1:0]   pe_out_fp16s,
    output logic                       pe_out_ready,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [$clog2(NUM_PE)-1:0]  m_idx,
    output logic                       m_last,
    output logic                       busy,
    output logic [31:0]                perf_tiles,
    output logic [31:0]                perf_stalls
);
    localparam int IW = $clog2(NUM_PE);
    state_t state_q, state_d;
    logic [NUM_PE-1:0] cap_q, cap_d, we;
    logic [IW-1:0] idx_q, idx_d;
    // A PE re-presenting a captured slot must stall everyone, since ready is shared
    assign pe_out_ready = (state_q == COLLECT) & ~|(pe_out_valid_vec & cap_q) & ~rst;
    assign we = pe_out_valid_vec & {NUM_PE{pe_out_ready}};
    assign m_valid = state_q == DRAIN;
    assign m_idx = idx_q;
    assign m_last = m_valid & (idx_q == IW'(NUM_PE - 1));
    assign busy = m_valid | |cap_q;
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        cap_d = cap_q;
        if (state_q == COLLECT) begin
            cap_d = cap_q | we;
            if (&cap_d) state_d = DRAIN;
        end else if (m_ready) begin
            idx_d = idx_q + IW'(1);
            if (m_last) begin
                idx_d = '0;
                cap_d = '0;
                state_d = COLLECT;
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= COLLECT;
            cap_q <= '0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            cap_q <= cap_d;
            idx_q <= idx_d;
        end
    pe_result_slot_buf #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) u_slots (
        .clk(clk), .we(we), .wdata(pe_out_fp16s), .rd_idx(idx_q), .rd_data(m_data)
    );
`ifdef PE_COLLECT_PERF_EN
    logic [31:0] tiles_q, stalls_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tiles_q <= '0;
            stalls_q <= '0;
        end else begin
            if (m_valid & m_ready & m_last) tiles_q <= tiles_q + 32'd1;
            if (|pe_out_valid_vec & ~pe_out_ready) stalls_q <= stalls_q + 32'd1;
        end
    assign perf_tiles = tiles_q;
    assign perf_stalls = stalls_q;
`else
    assign perf_tiles = '0;
    assign perf_stalls = '0;
`endif
endmodule
